// File: rtl/shift_add_mult_ctrl.sv
// Sequencer for a shift-add multiplier: LOAD, N x (TEST [ADD] SHIFT), DONE with start/done/ack handshake.
// Optional EARLY_EXIT_EN: finish as soon as the remaining multiplier is zero.
module shift_add_mult_ctrl #(
    parameter int N     = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             lsb,
    input  logic             mplr_zero,
    input  logic             ack,
    output logic             load,
    output logic             add,
    output logic             shift,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] iter
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_TEST  = 3'd2;
    localparam logic [2:0] S_ADD   = 3'd3;
    localparam logic [2:0] S_SHIFT = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(N - 1);

    logic [2:0]       r_state;
    logic [2:0]       w_next;
    logic [CNT_W-1:0] r_iter;
    logic             r_load;
    logic             r_add;
    logic             r_shift;
    logic             r_busy;
    logic             r_done;

`ifndef EARLY_EXIT_EN
    logic w_unused_mplr_zero;
    assign w_unused_mplr_zero = mplr_zero;
`endif

    // Next-state decode
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = S_LOAD;
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_LOAD: w_next = S_TEST;
            S_TEST: begin
`ifdef EARLY_EXIT_EN
                if (mplr_zero) begin
                    w_next = S_DONE;
                end else if (lsb) begin
                    w_next = S_ADD;
                end else begin
                    w_next = S_SHIFT;
                end
`else
                if (lsb) begin
                    w_next = S_ADD;
                end else begin
                    w_next = S_SHIFT;
                end
`endif
            end
            S_ADD: w_next = S_SHIFT;
            S_SHIFT: begin
                if (r_iter == LAST_ITER) begin
                    w_next = S_DONE;
                end else begin
                    w_next = S_TEST;
                end
            end
            S_DONE: begin
                if (ack && start) begin
                    w_next = S_LOAD;
                end else if (ack) begin
                    w_next = S_IDLE;
                end else begin
                    w_next = S_DONE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // State register and strobes registered from the next state so they track the state exactly
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_load  <= 1'b0;
            r_add   <= 1'b0;
            r_shift <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_load  <= (w_next == S_LOAD);
            r_add   <= (w_next == S_ADD);
            r_shift <= (w_next == S_SHIFT);
            r_busy  <= (w_next == S_LOAD) || (w_next == S_TEST) ||
                       (w_next == S_ADD)  || (w_next == S_SHIFT);
            r_done  <= (w_next == S_DONE);
        end
    end

    // Iteration counter: cleared by LOAD, bumped once per SHIFT, frozen otherwise
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_iter <= {CNT_W{1'b0}};
        end else if (r_state == S_LOAD) begin
            r_iter <= {CNT_W{1'b0}};
        end else if (r_state == S_SHIFT) begin
            r_iter <= r_iter + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            r_iter <= r_iter;
        end
    end

    assign load  = r_load;
    assign add   = r_add;
    assign shift = r_shift;
    assign busy  = r_busy;
    assign done  = r_done;
    assign iter  = r_iter;

endmodule
